// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared width, step function and checker state encoding for the LFSR stream checker
package lfsr_pkg;
  localparam int LFSR_W = 16;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} chk_state_t;
  function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] x);
    return {x[14:0], x[10] ^ x[8] ^ x[3] ^ x[1]};
  endfunction
endpackage

// File: rtl/lfsr_seq_checker_sat_counter.sv
// sat_counter: counter that sticks at all-ones; clear takes priority over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    count <= (reset || clr) ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: self-synchronising LFSR stream checker with flywheel error counting.
// Define LFSR_CHK_ERRLOG_EN to capture expected/received words of the first locked mismatch.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count,
  output logic [LFSR_W-1:0] first_exp,
  output logic [LFSR_W-1:0] first_got
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_COUNT - 1);
  chk_state_t state;
  logic [LFSR_W-1:0] pred;
  logic [MW-1:0] match;
  logic [LW-1:0] miss;
  logic hit, zero, inc_word, inc_err;
  assign hit      = in_data == pred;
  assign zero     = in_data == '0;
  assign inc_word = in_valid && state == LOCKED;
  assign inc_err  = inc_word && !hit;
  assign locked   = state == LOCKED;
  always_ff @(posedge clk)
    if (reset) begin
      state     <= SEARCH;
      pred      <= '0;
      match     <= '0;
      miss      <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= inc_err;
      if (in_valid)
        case (state)
          SEARCH: if (!zero) begin
            pred  <= lfsr16_next(in_data);
            match <= '0;
            state <= VERIFY;
          end
          VERIFY: if (zero) state <= SEARCH;
          else begin
            pred  <= lfsr16_next(in_data);
            match <= hit ? match + 1'b1 : '0;
            if (hit && match == LOCK_LAST) begin
              state <= LOCKED;
              miss  <= '0;
            end
          end
          default: begin
            // flywheel: once locked the prediction never follows the input
            pred <= lfsr16_next(pred);
            miss <= hit ? '0 : miss + 1'b1;
            if (!hit && miss == LOSS_LAST) state <= SEARCH;
          end
        endcase
    end
  sat_counter #(.W(CNT_W)) u_err (
    .clk(clk), .reset(reset), .inc(inc_err), .clr(clear_cnt), .count(err_count)
  );
  sat_counter #(.W(CNT_W)) u_word (
    .clk(clk), .reset(reset), .inc(inc_word), .clr(clear_cnt), .count(word_count)
  );
`ifdef LFSR_CHK_ERRLOG_EN
  logic captured;
  always_ff @(posedge clk)
    if (reset || clear_cnt) begin
      captured  <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
    end else if (inc_err && !captured) begin
      captured  <= 1'b1;
      first_exp <= pred;
      first_got <= in_data;
    end
`else
  assign first_exp = '0;
  assign first_got = '0;
`endif
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb_lfsr_seq_checker: directed stimulus on two checker instances (16- and 4-bit counters)
// compared every cycle against a rule-level model, plus hand-computed literal expectations.
module tb_lfsr_seq_checker;
`ifdef LFSR_CHK_ERRLOG_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, clear_cnt = 1'b0;
  logic [15:0] in_data = '0;
  logic l16, p16, l4, p4;
  logic [15:0] e16, w16, fe16, fg16, fe4, fg4;
  logic [3:0] e4, w4;
  int checks = 0, failures = 0;
  lfsr_seq_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clear_cnt(clear_cnt),
    .locked(l16), .err_pulse(p16), .err_count(e16), .word_count(w16),
    .first_exp(fe16), .first_got(fg16)
  );
  lfsr_seq_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clear_cnt(clear_cnt),
    .locked(l4), .err_pulse(p4), .err_count(e4), .word_count(w4),
    .first_exp(fe4), .first_got(fg4)
  );
  always #5 clk = ~clk;

  function automatic logic [15:0] nx(input logic [15:0] x);
    return {x[14:0], ^(x & 16'h050A)};
  endfunction
  function automatic int sat(input int v, input int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, got, exp, $time);
    end
  endtask

  // model: 0 = hunting, 1 = confirming, 2 = synchronised; counters kept unbounded
  int m_mode = 0, m_run = 0, m_bad = 0, m_err = 0, m_words = 0;
  logic [15:0] m_pred = '0, m_fexp = '0, m_fgot = '0;
  bit m_pulse = 0, m_fcap = 0;
  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_run = 0; m_bad = 0; m_err = 0; m_words = 0;
      m_pred = '0; m_fexp = '0; m_fgot = '0; m_pulse = 0; m_fcap = 0;
    end else begin
      m_pulse = 0;
      if (clear_cnt) begin
        m_err = 0; m_words = 0; m_fcap = 0; m_fexp = '0; m_fgot = '0;
      end
      if (in_valid) begin
        if (m_mode == 0) begin
          if (in_data != 0) begin m_pred = nx(in_data); m_run = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
          if (in_data == 0) m_mode = 0;
          else begin
            m_run = (in_data == m_pred) ? m_run + 1 : 0;
            m_pred = nx(in_data);
            if (m_run == 4) begin m_mode = 2; m_bad = 0; end
          end
        end else begin
          if (in_data == m_pred) begin
            m_bad = 0;
            if (!clear_cnt) m_words++;
          end else begin
            m_pulse = 1;
            if (!clear_cnt) begin
              m_err++; m_words++;
              if (EN && !m_fcap) begin m_fcap = 1; m_fexp = m_pred; m_fgot = in_data; end
            end
            m_bad++;
            if (m_bad == 3) m_mode = 0;
          end
          m_pred = nx(m_pred);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("locked16", l16, m_mode == 2);
    chk("pulse16", p16, m_pulse);
    chk("err16", e16, sat(m_err, 16));
    chk("words16", w16, sat(m_words, 16));
    chk("fexp16", fe16, m_fexp);
    chk("fgot16", fg16, m_fgot);
    chk("locked4", l4, m_mode == 2);
    chk("pulse4", p4, m_pulse);
    chk("err4", e4, sat(m_err, 4));
    chk("words4", w4, sat(m_words, 4));
    chk("fexp4", fe4, m_fexp);
    chk("fgot4", fg4, m_fgot);
  end

  logic [15:0] g, t;
  task automatic step(input logic v, input logic [15:0] d, input logic c);
    in_valid = v; in_data = d; clear_cnt = c;
    @(posedge clk); #1;
  endtask
  task automatic good();
    step(1'b1, g, 1'b0); g = nx(g);
  endtask
  task automatic bad(input logic [15:0] v);
    step(1'b1, v, 1'b0); g = nx(g);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", l16, 0); chk("rst_pulse", p16, 0);
    chk("rst_err", e16, 0); chk("rst_words", w16, 0);
    reset = 1'b0;
    // 1: seed + four matches locks, counting starts with the following word
    g = 16'h0001;
    repeat (4) good();
    chk("t1_not_yet", l16, 0);
    good();
    chk("t1_locked", l16, 1);
    chk("t1_gen", g, 16'h0028);
    good();
    chk("t1_words", w16, 1); chk("t1_err", e16, 0);
    // 2: single corrupted word while locked
    repeat (3) good();
    bad(16'h0000);
    chk("t2_pulse", p16, 1); chk("t2_err", e16, 1); chk("t2_locked", l16, 1);
    good();
    chk("t2_pulse_off", p16, 0); chk("t2_err_hold", e16, 1);
    chk("t2_words", w16, 6); chk("t2_flywheel", l16, 1);
    // 3: three consecutive bad words lose lock, clean stream relocks
    step(1'b0, 16'h0, 1'b1);
    chk("t3_clr", e16, 0);
    repeat (3) bad(g ^ 16'h0100);
    chk("t3_lost", l16, 0); chk("t3_err", e16, 3); chk("t3_words", w16, 3);
    repeat (4) good();
    chk("t3_not_yet", l16, 0);
    good();
    chk("t3_relock", l16, 1);
    // 4: idle gaps between words
    reset = 1'b1; step(1'b0, 16'h0, 1'b0); reset = 1'b0;
    g = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      good();
      step(1'b0, 16'h0, 1'b0); step(1'b0, 16'h0, 1'b0);
      if (i == 3) chk("t4_not_yet", l16, 0);
      if (i == 4) chk("t4_locked", l16, 1);
    end
    chk("t4_words", w16, 1); chk("t4_err", e16, 0);
    // 5: saturation, clear-vs-error priority, first-error capture
    step(1'b0, 16'h0, 1'b1);
    for (int r = 0; r < 7; r++) begin
      repeat (3) bad(g ^ 16'h0100);
      repeat (5) good();
    end
    chk("t5_sat4", e4, 4'hF); chk("t5_err16", e16, 21); chk("t5_locked", l16, 1);
    step(1'b1, g ^ 16'h0100, 1'b1); g = nx(g);
    chk("t5_clr_err16", e16, 0); chk("t5_clr_err4", e4, 0); chk("t5_clr_pulse", p16, 1);
    t = g;
    bad(g ^ 16'h0200);
    chk("t5_err_after", e16, 1);
    chk("t5_fexp", fe16, EN ? int'(t) : 0);
    chk("t5_fgot", fg16, EN ? int'(t ^ 16'h0200) : 0);
    good(); good();
    chk("t5_still_locked", l16, 1);
    // 6: zeros in hunt, reset while locked
    reset = 1'b1; step(1'b0, 16'h0, 1'b0); reset = 1'b0;
    repeat (3) step(1'b1, 16'h0000, 1'b0);
    chk("t6_zero", l16, 0);
    g = 16'hACE1;
    repeat (5) good();
    chk("t6_locked", l16, 1);
    bad(16'h1234);
    reset = 1'b1; step(1'b1, g, 1'b0);
    chk("t6_rst_locked", l16, 0); chk("t6_rst_pulse", p16, 0);
    chk("t6_rst_err", e16, 0); chk("t6_rst_words", w16, 0);
    reset = 1'b0;
    step(1'b0, 16'h0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
